fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL provide parameter DEPTH, default 4: instruction buffer entries, power of two, 2..16.
REQ-003 SHALL provide port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL provide port redirect_valid  input  1: the branch/jump unit redirects fetch this cycle.
REQ-006 SHALL provide port redirect_pc  input  32: redirect target, word aligned.
REQ-007 SHALL provide port mem_req_valid  output  1: an instruction memory read request is presented.
REQ-008 SHALL provide port mem_req_addr  output  32: request byte address.
REQ-009 SHALL provide port mem_req_ready  input  1: memory accepts the request this cycle.
REQ-010 SHALL provide port mem_rsp_valid  input  1: read data is returned this cycle, in request order.
REQ-011 SHALL provide port mem_rsp_data  input  32: returned instruction word.
REQ-012 SHALL provide port instr_valid  output  1: buffer head is valid for the decode/controller stage.
REQ-013 SHALL provide port instr  output  32: head instruction word.
REQ-014 SHALL provide port instr_pc  output  32: PC of the head instruction.
REQ-015 SHALL provide port instr_ready  input  1: the downstream stage consumes the head this cycle.

Function
REQ-016 SHALL transfer a request when mem_req_valid and mem_req_ready are both 1; fetch_pc SHALL then advance by 4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-017 SHALL hold mem_req_addr stable while mem_req_valid=1 and mem_req_ready=0.
REQ-018 SHALL assert mem_req_valid only while outstanding + occupancy < DEPTH, so a response always has a free slot.
REQ-019 SHALL write each non-discarded response into the buffer with its PC in the cycle mem_rsp_valid=1; memory latency is at least 1 cycle, unbounded.
REQ-020 SHALL pop the head when instr_valid and instr_ready are both 1; instr_valid SHALL equal (occupancy != 0).
REQ-021 SHALL process a push and a pop in the same cycle on a full buffer without loss; occupancy SHALL then be unchanged.
REQ-022 SHALL, on redirect_valid=1, flush the buffer (instr_valid=0 next cycle), set fetch_pc=redirect_pc, and load a discard counter with the current outstanding count, including any request transferring that cycle.
REQ-023 SHALL drop responses while the discard counter is nonzero, decrementing it per response; it SHALL NOT issue a redirected request in the redirect cycle itself.
REQ-024 SHALL give redirect priority over a same-cycle pop; a same-cycle response SHALL count as discarded.
REQ-025 SHALL present the head combinationally from buffer registers, with no path from mem_rsp_* to instr*; minimum latency is request to instr_valid = memory latency + 1 cycle.
REQ-026 SHALL treat mem_rsp_valid with zero outstanding requests as a protocol error and ignore it.

Reset
REQ-027 SHALL, while reset=0, clear occupancy, outstanding count, discard counter and pointers, and set fetch_pc=RESET_PC.
REQ-028 SHALL drive mem_req_valid=0, instr_valid=0, instr=0, instr_pc=0 and mem_req_addr=RESET_PC during reset.
REQ-029 SHALL issue the first request (addr RESET_PC) no earlier than the first rising edge after reset deasserts; reset asserted mid-transfer SHALL abandon all state, and any later stale responses fall under REQ-026.

Configuration
REQ-030 SHALL, with FETCH_STALL_CNT_EN defined, add output stall_cycles (32 bits, reset 0) that increments with wrap each cycle instr_ready=1 and instr_valid=0.
REQ-031 SHALL, without FETCH_STALL_CNT_EN, omit the stall_cycles port and all its logic.

Verification
REQ-032 SHALL cover: reset release, memory ready always, 1-cycle latency, instr_ready=1 -> instr_pc 0,4,8,12 on consecutive cycles after the fill latency.
REQ-033 SHALL cover: instr_ready=0, DEPTH=4 -> exactly 4 requests issued, then mem_req_valid=0; one pop -> exactly one further request.
REQ-034 SHALL cover: redirect to 32'h0000_0100 with 2 requests outstanding -> 2 responses dropped, next instr_pc=32'h100, no stale word appears at the output.
REQ-035 SHALL cover: mem_req_ready=0 for 5 cycles -> mem_req_addr constant, no duplicate or skipped PC.
REQ-036 SHALL cover: redirect_pc=32'hFFFF_FFFC -> next fetch address 0.
REQ-037 SHALL cover: with FETCH_STALL_CNT_EN defined, 3 starved cycles with instr_ready=1 -> stall_cycles=3.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a small in-order buffer.
//
// The unit issues word-aligned read requests starting at RESET_PC. It only
// requests when a buffer slot is guaranteed for the response. Returned words
// are queued together with their PC and handed to the decode stage from the
// buffer head. A redirect flushes the buffer, restarts fetch at the new PC
// and drops every response that is still in flight.
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   DEPTH     buffer entries (power of two, 2..16)
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   redirect_valid/redirect_pc  fetch redirect and its target
//   mem_req_valid/addr/ready    instruction memory request handshake
//   mem_rsp_valid/data          in-order read data, latency >= 1 cycle
//   instr_valid/instr/instr_pc  buffer head presented to decode
//   instr_ready                 decode consumes the head this cycle
//   stall_cycles                only when FETCH_STALL_CNT_EN is defined:
//                               cycles where decode was ready but starved
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);        // pointer width
  localparam int CW = $clog2(DEPTH + 1);    // counter width, holds 0..DEPTH
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;   // address of the next request
  logic [31:0]   rsp_pc;     // PC of the next response that will be kept
  logic          run;        // low until the first edge after reset release
  logic [CW-1:0] out_cnt;    // requests transferred but not yet answered
  logic [CW-1:0] occ;        // valid buffer entries
  logic [CW-1:0] disc;       // in-flight responses still to be dropped
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];

  logic          xfer;
  logic          rsp_fire;
  logic          drop;
  logic          push;
  logic          pop;
  logic [CW:0]   inflight;
  logic [CW-1:0] out_nxt;

  // Counting outstanding requests against the buffer keeps a free slot for
  // every response, so the memory side never needs back-pressure.
  assign inflight      = {1'b0, out_cnt} + {1'b0, occ};
  assign mem_req_valid = run && (inflight < DEPTH_W);
  assign mem_req_addr  = fetch_pc;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign xfer     = mem_req_valid && mem_req_ready;
  assign rsp_fire = mem_rsp_valid && (out_cnt != '0);
  assign drop     = rsp_fire && (redirect_valid || (disc != '0));
  assign push     = rsp_fire && !drop;
  assign pop      = instr_valid && instr_ready && !redirect_valid;
  assign out_nxt  = out_cnt + CW'(xfer) - CW'(rsp_fire);

  // Head comes straight from buffer registers; zero whenever empty.
  assign instr_valid = (occ != '0);
  assign instr       = instr_valid ? fifo_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      run      <= 1'b0;
      out_cnt  <= '0;
      occ      <= '0;
      disc     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      run     <= 1'b1;
      out_cnt <= out_nxt;
      if (redirect_valid) begin
        // Everything still in flight, including a request transferring in
        // this same cycle, belongs to the old path and must be discarded.
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        disc     <= out_nxt;
        occ      <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (xfer) fetch_pc <= fetch_pc + 32'd4;
        if (drop) disc <= disc - CW'(1);
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end

  // NOTE: buffer storage has no reset; entries are only visible through
  // instr_valid, which comes from the reset occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_rsp_data;
      fifo_pc[wr_ptr]   <= rsp_pc;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (instr_ready && !instr_valid) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
